// File: rtl/spi_slave_regfile.sv
// SPI slave register file: configurable CPOL/CPHA/bit order, auto-incrementing byte bursts.
// Optional write-notify outputs are enabled by defining SPI_SLAVE_WR_NOTIFY_EN.
module spi_slave_regfile #(
    parameter int REG_BYTES = 50,
    parameter int ADDR_BITS = 15,
    parameter int CPOL      = 1,
    parameter int CPHA      = 1,
    parameter int LSB_FIRST = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   sck,
    input  logic                   cs,
    input  logic                   mosi,
    output logic                   miso,
    output logic [8*REG_BYTES-1:0] reg_bits,
    output logic                   active,
    output logic                   wr_valid,
    output logic [ADDR_BITS-1:0]   wr_addr,
    output logic [7:0]             wr_data
);

    // state  | meaning
    // IDLE   | cs high, everything cleared
    // HDR    | shifting address bits, then the R/W bit
    // RD     | shifting register bytes out on miso
    // WR     | shifting bytes in from mosi and committing them
    typedef enum logic [1:0] {S_IDLE, S_HDR, S_RD, S_WR} state_t;

    localparam int CNT_W = ($clog2(ADDR_BITS + 1) > 3) ? $clog2(ADDR_BITS + 1) : 3;
    localparam logic SCK_IDLE = (CPOL != 0);
    localparam logic SAMPLE_RISE = (CPOL == CPHA);
    localparam logic LSB = (LSB_FIRST != 0);
    localparam logic [ADDR_BITS-1:0] REG_BYTES_A = ADDR_BITS'(REG_BYTES);

    logic sck_s1_q, sck_s2_q, sck_s3_q;
    logic cs_s1_q, cs_s2_q;
    logic mosi_s1_q, mosi_s2_q;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic [ADDR_BITS-1:0] addr_q, addr_d;
    logic [7:0]           rx_q, rx_d;
    logic [7:0]           tx_q, tx_d;
    logic                 miso_q, miso_d;
    logic [8*REG_BYTES-1:0] reg_q;

    logic       sck_rise, sck_fall, sample_edge, shift_edge;
    logic       commit, in_range, commit_we;
    logic [7:0] rd_byte, cur_byte;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sck_s1_q  <= SCK_IDLE;
            sck_s2_q  <= SCK_IDLE;
            sck_s3_q  <= SCK_IDLE;
            cs_s1_q   <= 1'b1;
            cs_s2_q   <= 1'b1;
            mosi_s1_q <= 1'b0;
            mosi_s2_q <= 1'b0;
        end else begin
            sck_s1_q  <= sck;
            sck_s2_q  <= sck_s1_q;
            sck_s3_q  <= sck_s2_q;
            cs_s1_q   <= cs;
            cs_s2_q   <= cs_s1_q;
            mosi_s1_q <= mosi;
            mosi_s2_q <= mosi_s1_q;
        end
    end

    assign sck_rise    = sck_s2_q & ~sck_s3_q;
    assign sck_fall    = ~sck_s2_q & sck_s3_q;
    assign sample_edge = SAMPLE_RISE ? sck_rise : sck_fall;
    assign shift_edge  = SAMPLE_RISE ? sck_fall : sck_rise;
    assign in_range    = (addr_q < REG_BYTES_A);
    assign commit_we   = commit & in_range;

    // Out-of-range addresses match no byte and read as zero.
    always_comb begin
        rd_byte = '0;
        for (int i = 0; i < REG_BYTES; i++) begin
            if (addr_q == ADDR_BITS'(i)) rd_byte = reg_q[8*i +: 8];
        end
    end

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        addr_d    = addr_q;
        rx_d      = rx_q;
        tx_d      = tx_q;
        miso_d    = (state_q == S_RD) ? miso_q : 1'b0;
        commit    = 1'b0;
        cur_byte  = '0;
        if (cs_s2_q) begin
            // CS high overrides any coincident SCK edge.
            state_d   = S_IDLE;
            bit_cnt_d = '0;
            addr_d    = '0;
            rx_d      = '0;
            tx_d      = '0;
            miso_d    = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: state_d = S_HDR;
                S_HDR: begin
                    if (sample_edge) begin
                        if (bit_cnt_q == CNT_W'(ADDR_BITS)) begin
                            state_d   = mosi_s2_q ? S_RD : S_WR;
                            bit_cnt_d = '0;
                        end else begin
                            addr_d = LSB ? {mosi_s2_q, addr_q[ADDR_BITS-1:1]}
                                         : {addr_q[ADDR_BITS-2:0], mosi_s2_q};
                            bit_cnt_d = bit_cnt_q + CNT_W'(1);
                        end
                    end
                end
                S_RD: begin
                    if (shift_edge) begin
                        // Snapshot the byte on its first shift edge.
                        cur_byte = (bit_cnt_q == '0) ? rd_byte : tx_q;
                        miso_d   = LSB ? cur_byte[0] : cur_byte[7];
                        tx_d     = LSB ? (cur_byte >> 1) : (cur_byte << 1);
                        if (bit_cnt_q == CNT_W'(7)) begin
                            bit_cnt_d = '0;
                            addr_d    = addr_q + ADDR_BITS'(1);
                        end else begin
                            bit_cnt_d = bit_cnt_q + CNT_W'(1);
                        end
                    end
                end
                S_WR: begin
                    if (sample_edge) begin
                        rx_d = LSB ? {mosi_s2_q, rx_q[7:1]} : {rx_q[6:0], mosi_s2_q};
                        if (bit_cnt_q == CNT_W'(7)) begin
                            commit    = 1'b1;
                            bit_cnt_d = '0;
                            addr_d    = addr_q + ADDR_BITS'(1);
                        end else begin
                            bit_cnt_d = bit_cnt_q + CNT_W'(1);
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            bit_cnt_q <= '0;
            addr_q    <= '0;
            rx_q      <= '0;
            tx_q      <= '0;
            miso_q    <= 1'b0;
            reg_q     <= '0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            addr_q    <= addr_d;
            rx_q      <= rx_d;
            tx_q      <= tx_d;
            miso_q    <= miso_d;
            for (int i = 0; i < REG_BYTES; i++) begin
                if (commit_we && addr_q == ADDR_BITS'(i)) reg_q[8*i +: 8] <= rx_d;
            end
        end
    end

    assign miso     = miso_q;
    assign reg_bits = reg_q;
    assign active   = ~cs_s2_q;

`ifdef SPI_SLAVE_WR_NOTIFY_EN
    logic                 wr_valid_q;
    logic [ADDR_BITS-1:0] wr_addr_q;
    logic [7:0]           wr_data_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_valid_q <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
        end else begin
            wr_valid_q <= commit_we;
            if (commit_we) begin
                wr_addr_q <= addr_q;
                wr_data_q <= rx_d;
            end
        end
    end

    assign wr_valid = wr_valid_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;
`else
    assign wr_valid = 1'b0;
    assign wr_addr  = '0;
    assign wr_data  = '0;
`endif

endmodule

// File: tb/tb_spi_slave_regfile.sv
// Directed bench: instance A is mode 3 LSB-first, instance B is mode 0 MSB-first.
module tb_spi_slave_regfile;

`ifdef SPI_SLAVE_WR_NOTIFY_EN
    localparam int NTF = 1;
`else
    localparam int NTF = 0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic         sck_a = 1'b1, cs_a = 1'b1, mosi_a = 1'b0, miso_a;
    logic [399:0] reg_bits_a;
    logic         active_a, wr_valid_a;
    logic [14:0]  wr_addr_a;
    logic [7:0]   wr_data_a;

    logic         sck_b = 1'b0, cs_b = 1'b1, mosi_b = 1'b0, miso_b;
    logic [399:0] reg_bits_b;
    logic         active_b, wr_valid_b;
    logic [14:0]  wr_addr_b;
    logic [7:0]   wr_data_b;

    int checks = 0;
    int errors = 0;
    int wv_cnt = 0;
    logic [14:0] wv_addr [8];
    logic [7:0]  wv_data [8];

    always #5 clk = ~clk;

    spi_slave_regfile #(.REG_BYTES(50), .ADDR_BITS(15), .CPOL(1), .CPHA(1), .LSB_FIRST(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .sck(sck_a), .cs(cs_a), .mosi(mosi_a), .miso(miso_a),
        .reg_bits(reg_bits_a), .active(active_a), .wr_valid(wr_valid_a),
        .wr_addr(wr_addr_a), .wr_data(wr_data_a));

    spi_slave_regfile #(.REG_BYTES(50), .ADDR_BITS(15), .CPOL(0), .CPHA(0), .LSB_FIRST(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .sck(sck_b), .cs(cs_b), .mosi(mosi_b), .miso(miso_b),
        .reg_bits(reg_bits_b), .active(active_b), .wr_valid(wr_valid_b),
        .wr_addr(wr_addr_b), .wr_data(wr_data_b));

    always @(negedge clk) begin
        if (wr_valid_a) begin
            if (wv_cnt < 8) begin
                wv_addr[wv_cnt] = wr_addr_a;
                wv_data[wv_cnt] = wr_data_a;
            end
            wv_cnt++;
        end
    end

    task automatic chk(input string tag, input logic [399:0] obs, input logic [399:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic half();
        repeat (8) @(negedge clk);
    endtask

    task automatic bit_io(input bit dev, input logic b, output logic r);
        if (dev == 1'b0) begin
            sck_a  = 1'b0;
            mosi_a = b;
            half();
            r = miso_a;
            sck_a = 1'b1;
            half();
        end else begin
            mosi_b = b;
            half();
            r = miso_b;
            sck_b = 1'b1;
            half();
            sck_b = 1'b0;
        end
    endtask

    // dev 0 -> instance A (LSB first), dev 1 -> instance B (MSB first)
    task automatic xfer(input bit dev, input logic [14:0] addr, input logic rd, input int nbits,
                        input logic [31:0] wdata, output logic [31:0] rdata, output logic hdr_miso);
        logic b, r;
        int   idx;
        bit   lsb;
        lsb = (dev == 1'b0);
        hdr_miso = 1'b0;
        rdata = '0;
        if (dev == 1'b0) cs_a = 1'b0; else cs_b = 1'b0;
        half();
        for (int i = 0; i < 15; i++) begin
            b = lsb ? addr[i] : addr[14-i];
            bit_io(dev, b, r);
            hdr_miso = hdr_miso | r;
        end
        bit_io(dev, rd, r);
        hdr_miso = hdr_miso | r;
        for (int i = 0; i < nbits; i++) begin
            idx = 8 * (i / 8) + (lsb ? (i % 8) : (7 - (i % 8)));
            b = wdata[idx];
            bit_io(dev, b, r);
            rdata[idx] = r;
        end
        half();
        if (dev == 1'b0) cs_a = 1'b1; else cs_b = 1'b1;
        half();
    endtask

    logic [399:0] exp_a;
    logic [31:0]  rd;
    logic         hm;

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_miso", miso_a, 0);
        chk("rst_reg_bits", reg_bits_a, 0);
        chk("rst_active", active_a, 0);
        chk("rst_wr_valid", wr_valid_a, 0);
        chk("rst_wr_addr", wr_addr_a, 0);
        chk("rst_wr_data", wr_data_a, 0);
        chk("rst_miso_b", miso_b, 0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        cs_a = 1'b0;
        repeat (3) @(negedge clk);
        chk("active_on", active_a, 1);
        cs_a = 1'b1;
        repeat (3) @(negedge clk);
        chk("active_off", active_a, 0);

        // Mode 3 write burst A5, 3C at addr 2
        xfer(1'b0, 15'd2, 1'b0, 16, 32'h0000_3CA5, rd, hm);
        exp_a = '0;
        exp_a[23:16] = 8'hA5;
        exp_a[31:24] = 8'h3C;
        chk("wr_byte2", reg_bits_a[23:16], 8'hA5);
        chk("wr_byte3", reg_bits_a[31:24], 8'h3C);
        chk("wr_vector", reg_bits_a, exp_a);
        chk("wr_pulses", wv_cnt, 2 * NTF);
`ifdef SPI_SLAVE_WR_NOTIFY_EN
        chk("wr_addr0", wv_addr[0], 15'd2);
        chk("wr_addr1", wv_addr[1], 15'd3);
        chk("wr_data0", wv_data[0], 8'hA5);
        chk("wr_data1", wv_data[1], 8'h3C);
`endif

        // Mode 3 read back 2 bytes
        xfer(1'b0, 15'd2, 1'b1, 16, 32'h0, rd, hm);
        chk("rd_byte2", rd[7:0], 8'hA5);
        chk("rd_byte3", rd[15:8], 8'h3C);
        chk("rd_hdr_miso", hm, 0);

        // Mode 0, MSB first
        xfer(1'b1, 15'd0, 1'b0, 8, 32'h81, rd, hm);
        chk("m0_wr_vector", reg_bits_b, 400'h81);
        xfer(1'b1, 15'd0, 1'b1, 8, 32'h0, rd, hm);
        chk("m0_rd_byte0", rd[7:0], 8'h81);

        // Burst crossing the top of the array
        xfer(1'b0, 15'd49, 1'b0, 16, 32'h0000_2211, rd, hm);
        exp_a[399:392] = 8'h11;
        chk("top_last_byte", reg_bits_a[399:392], 8'h11);
        chk("top_vector", reg_bits_a, exp_a);
        chk("top_pulses", wv_cnt, 3 * NTF);
        xfer(1'b0, 15'd49, 1'b1, 16, 32'h0, rd, hm);
        chk("top_rd49", rd[7:0], 8'h11);
        chk("top_rd50", rd[15:8], 8'h00);

        // CS raised after 5 data bits
        xfer(1'b0, 15'd4, 1'b0, 5, 32'hFF, rd, hm);
        chk("part_vector", reg_bits_a, exp_a);
        chk("part_pulses", wv_cnt, 3 * NTF);
        xfer(1'b0, 15'd3, 1'b1, 8, 32'h0, rd, hm);
        chk("part_next_rd", rd[7:0], 8'h3C);

        // Reset in the middle of a read
        fork
            xfer(1'b0, 15'd2, 1'b1, 16, 32'h0, rd, hm);
            begin
                repeat (310) @(negedge clk);
                rst_n = 1'b0;
                #1;
                chk("mid_rst_miso", miso_a, 0);
                chk("mid_rst_reg_bits", reg_bits_a, 0);
            end
        join
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        xfer(1'b0, 15'd1, 1'b0, 8, 32'h5A, rd, hm);
        chk("post_rst_vector", reg_bits_a, 400'h5A00);
        xfer(1'b0, 15'd1, 1'b1, 8, 32'h0, rd, hm);
        chk("post_rst_rd", rd[7:0], 8'h5A);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
